// File: rtl/cardinal_input_port.sv
// Router input channel: two 1-deep virtual-channel buffers, polarity-selected
// write/read roles, and a hop-decrementing forward path to the output arbiters.
module cardinal_input_port #(
    parameter int PACKET_SIZE = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   polarity,
    input  logic                   up_si,
    output logic                   up_ri,
    input  logic [0:PACKET_SIZE-1] up_di,
    output logic                   ring_req,
    output logic                   ring_dir,
    output logic                   pe_req,
    input  logic                   ring_gnt,
    input  logic                   pe_gnt,
    output logic [0:PACKET_SIZE-1] fwd_do,
    output logic [0:1]             vc_full
);

    logic [0:PACKET_SIZE-1] vcBuf0_q, vcBuf1_q;
    logic [0:PACKET_SIZE-1] vcBuf0_d, vcBuf1_d;
    logic                   vcFull0_q, vcFull1_q;
    logic                   vcFull0_d, vcFull1_d;

    logic                   extVc;
    logic                   extFull;
    logic                   intFull;
    logic [0:PACKET_SIZE-1] intBuf;
    logic [0:7]             hop;
    logic                   wrEn;
    logic                   grantTaken;

    // Polarity=1 makes VC0 the receiving buffer and VC1 the forwarding one.
    assign extVc   = ~polarity;
    assign extFull = polarity ? vcFull0_q : vcFull1_q;
    assign intFull = polarity ? vcFull1_q : vcFull0_q;
    assign intBuf  = polarity ? vcBuf1_q  : vcBuf0_q;
    assign hop     = intBuf[8:15];

    assign up_ri      = ~extFull;
    assign wrEn       = up_si & up_ri & (up_di[0] == extVc);
    assign ring_req   = intFull & (hop != 8'd0);
    assign pe_req     = intFull & (hop == 8'd0);
    assign ring_dir   = intFull & intBuf[1];
    assign grantTaken = (ring_req & ring_gnt) | (pe_req & pe_gnt);
    assign vc_full    = {vcFull0_q, vcFull1_q};

    always_comb begin
        fwd_do = '0;
        if (intFull) begin
            fwd_do = intBuf;
            if (hop != 8'd0) begin
                fwd_do[8:15] = hop - 8'd1;
            end
        end
    end

    // Roles never coincide, so each buffer sees either a write or a release.
    always_comb begin
        vcBuf0_d  = vcBuf0_q;
        vcBuf1_d  = vcBuf1_q;
        vcFull0_d = vcFull0_q;
        vcFull1_d = vcFull1_q;
        if (polarity) begin
            if (wrEn) begin
                vcBuf0_d  = up_di;
                vcFull0_d = 1'b1;
            end
            if (grantTaken) begin
                vcFull1_d = 1'b0;
            end
        end else begin
            if (wrEn) begin
                vcBuf1_d  = up_di;
                vcFull1_d = 1'b1;
            end
            if (grantTaken) begin
                vcFull0_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vcBuf0_q  <= '0;
            vcBuf1_q  <= '0;
            vcFull0_q <= 1'b0;
            vcFull1_q <= 1'b0;
        end else begin
            vcBuf0_q  <= vcBuf0_d;
            vcBuf1_q  <= vcBuf1_d;
            vcFull0_q <= vcFull0_d;
            vcFull1_q <= vcFull1_d;
        end
    end

endmodule

// File: tb/tb_cardinal_input_port.sv
// Directed-vector bench for cardinal_input_port with hand-computed expectations.
module tb_cardinal_input_port;

    logic        clk;
    logic        reset;
    logic        polarity;
    logic        up_si;
    logic        up_ri;
    logic [0:63] up_di;
    logic        ring_req;
    logic        ring_dir;
    logic        pe_req;
    logic        ring_gnt;
    logic        pe_gnt;
    logic [0:63] fwd_do;
    logic [0:1]  vc_full;

    int errorCount = 0;
    int checkCount = 0;

    logic [0:63] pktA, pktB, pktC, pktD, pktE, pktF, pktG, pktH, expPkt;

    cardinal_input_port #(.PACKET_SIZE(64)) dut (
        .clk      (clk),
        .reset    (reset),
        .polarity (polarity),
        .up_si    (up_si),
        .up_ri    (up_ri),
        .up_di    (up_di),
        .ring_req (ring_req),
        .ring_dir (ring_dir),
        .pe_req   (pe_req),
        .ring_gnt (ring_gnt),
        .pe_gnt   (pe_gnt),
        .fwd_do   (fwd_do),
        .vc_full  (vc_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [0:63] mkPkt(input logic vc, input logic dir,
                                          input logic [7:0] hopVal,
                                          input logic [63:0] payload);
        logic [0:63] p;
        p       = payload;
        p[0]    = vc;
        p[1]    = dir;
        p[8:15] = hopVal;
        return p;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got,
                               input logic [63:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic pol, input logic si,
                                 input logic [0:63] di, input logic rg,
                                 input logic pg);
        polarity = pol;
        up_si    = si;
        up_di    = di;
        ring_gnt = rg;
        pe_gnt   = pg;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        pktA = mkPkt(1'b0, 1'b1, 8'h03, 64'h00A1_B2C3_D4E5_F607);
        pktB = mkPkt(1'b1, 1'b0, 8'h00, 64'h1234_5678_9ABC_DEF0);
        pktC = mkPkt(1'b0, 1'b0, 8'h05, 64'h0F0F_0F0F_F0F0_F0F0);
        pktD = mkPkt(1'b0, 1'b1, 8'h09, 64'hFFFF_0000_FFFF_0000);
        pktE = mkPkt(1'b1, 1'b0, 8'h07, 64'hCAFE_BABE_0000_1111);
        pktF = mkPkt(1'b0, 1'b1, 8'h00, 64'hDEAD_BEEF_2222_3333);
        pktG = mkPkt(1'b0, 1'b1, 8'h03, 64'h5555_AAAA_5555_AAAA);
        pktH = mkPkt(1'b1, 1'b1, 8'h01, 64'h7777_8888_9999_AAAA);

        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0);
        tick();
        #2;
        checkOutput("rst_up_ri", up_ri, 1);
        checkOutput("rst_ring_req", ring_req, 0);
        checkOutput("rst_pe_req", pe_req, 0);
        checkOutput("rst_ring_dir", ring_dir, 0);
        checkOutput("rst_fwd_do", fwd_do, 0);
        checkOutput("rst_vc_full", vc_full, 0);
        reset = 1'b0;
        tick();

        // Ring forward: VC0, hop 3, counter-clockwise
        applyStimulus(1'b1, 1'b1, pktA, 1'b0, 1'b0);
        #2;
        checkOutput("ringfwd_up_ri", up_ri, 1);
        tick();
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
        #2;
        expPkt = pktA;
        expPkt[8:15] = 8'h02;
        checkOutput("ringfwd_vc_full", vc_full, 2'b10);
        checkOutput("ringfwd_ring_req", ring_req, 1);
        checkOutput("ringfwd_pe_req", pe_req, 0);
        checkOutput("ringfwd_ring_dir", ring_dir, 1);
        checkOutput("ringfwd_hop", fwd_do[8:15], 8'h02);
        checkOutput("ringfwd_fwd_do", fwd_do, expPkt);
        ring_gnt = 1'b1;
        tick();
        ring_gnt = 1'b0;
        #2;
        checkOutput("ringfwd_freed", vc_full, 2'b00);
        checkOutput("ringfwd_req_off", ring_req, 0);
        checkOutput("ringfwd_fwd_zero", fwd_do, 0);

        // Ejection: VC1, hop 0
        applyStimulus(1'b0, 1'b1, pktB, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0);
        #2;
        checkOutput("eject_vc_full", vc_full, 2'b01);
        checkOutput("eject_pe_req", pe_req, 1);
        checkOutput("eject_ring_req", ring_req, 0);
        checkOutput("eject_fwd_do", fwd_do, pktB);
        pe_gnt = 1'b1;
        tick();
        pe_gnt = 1'b0;
        #2;
        checkOutput("eject_freed", vc_full, 2'b00);

        // Backpressure: VC0 full, second packet must not overwrite it
        applyStimulus(1'b1, 1'b1, pktC, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b1, pktD, 1'b0, 1'b0);
        #2;
        checkOutput("bp_up_ri", up_ri, 0);
        tick();
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
        #2;
        expPkt = pktC;
        expPkt[8:15] = 8'h04;
        checkOutput("bp_vc_full", vc_full, 2'b10);
        checkOutput("bp_ring_req", ring_req, 1);
        checkOutput("bp_ring_dir", ring_dir, 0);
        checkOutput("bp_fwd_do", fwd_do, expPkt);
        pe_gnt = 1'b1;
        tick();
        pe_gnt = 1'b0;
        #2;
        checkOutput("spurious_pe_gnt", vc_full, 2'b10);
        ring_gnt = 1'b1;
        tick();
        ring_gnt = 1'b0;
        #2;
        checkOutput("bp_freed", vc_full, 2'b00);

        // Mismatched VC bit is ignored
        applyStimulus(1'b1, 1'b1, pktE, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0);
        #2;
        checkOutput("mismatch_vc_full", vc_full, 2'b00);

        // Concurrent: VC1 granted while VC0 is written in the same cycle
        applyStimulus(1'b0, 1'b1, pktE, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b1, pktF, 1'b1, 1'b0);
        #2;
        checkOutput("conc_before", vc_full, 2'b01);
        checkOutput("conc_ring_req", ring_req, 1);
        checkOutput("conc_up_ri", up_ri, 1);
        tick();
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
        #2;
        checkOutput("conc_after", vc_full, 2'b10);
        checkOutput("conc_pe_req", pe_req, 1);
        checkOutput("conc_fwd_do", fwd_do, pktF);
        tick();
        #2;
        checkOutput("spurious_ring_gnt", vc_full, 2'b10);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
        tick();
        pe_gnt = 1'b0;
        #2;
        checkOutput("conc_freed", vc_full, 2'b00);

        // Asynchronous reset with both VCs full
        applyStimulus(1'b1, 1'b1, pktG, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b1, pktH, 1'b0, 1'b0);
        tick();
        up_si = 1'b0;
        #1;
        checkOutput("arst_pre_full", vc_full, 2'b11);
        checkOutput("arst_pre_ring_req", ring_req, 1);
        checkOutput("arst_pre_up_ri", up_ri, 0);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("arst_vc_full", vc_full, 2'b00);
        checkOutput("arst_ring_req", ring_req, 0);
        checkOutput("arst_up_ri", up_ri, 1);
        checkOutput("arst_fwd_do", fwd_do, 0);
        tick();
        reset = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule

// File: doc/cardinal_input_port.md
Name: cardinal_input_port

Overview:
- Router input channel placed directly downstream of cardinal_nic (and of each neighbouring router's output).
- Accepts packets over the si/ri handshake into two 1-deep virtual-channel (VC) buffers, selected by the polarity rule.
- Presents the internally active VC's packet to the router's output arbiters, either the ring output in the packet's direction or local ejection to the PE, with the hop field updated.

Parameters:
- PACKET_SIZE, 64, packet width in bits. Bit 0 = VC, bit 1 = direction (0 = clockwise, 1 = counter-clockwise), bits 8:15 = hop field (unsigned).

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- polarity  input  1  router polarity; same signal that cardinal_nic receives as net_polarity
- up_si  input  1  upstream send
- up_ri  output  1  ready to upstream
- up_di  input  [0:PACKET_SIZE-1]  upstream packet
- ring_req  output  1  request to the ring output arbiter
- ring_dir  output  1  direction of ring_req; copy of the held packet's bit 1
- pe_req  output  1  request to the PE ejection arbiter
- ring_gnt  input  1  grant for ring_req
- pe_gnt  input  1  grant for pe_req
- fwd_do  output  [0:PACKET_SIZE-1]  packet offered downstream, with the hop field already updated
- vc_full  output  [0:1]  full flags of VC0 and VC1 buffers

Behaviour:
- State: vc_buf[0], vc_buf[1] (PACKET_SIZE bits each) and vc_full[0], vc_full[1].
- Reset: all buffers and full flags cleared to 0. Outputs during and after reset: up_ri = 1, ring_req = 0, pe_req = 0, ring_dir = 0, fwd_do = 0.
- Reset asserted mid-transfer discards any held packet immediately, with no grant needed.
- VC roles per cycle:
  - ext_vc = polarity ? 0 : 1 (VC accepting upstream writes).
  - int_vc = ~ext_vc (VC offered downstream).
  - The two roles never coincide, so a write and a read never target the same buffer in one cycle.
- Receive side:
  - up_ri = ~vc_full[ext_vc], combinational.
  - Write when up_si & up_ri & (up_di[0] == ext_vc): vc_buf[ext_vc] <= up_di and vc_full[ext_vc] <= 1 at the next edge.
  - up_si with mismatched VC bit: ignored, no state change. The upstream is responsible; this is not an error.
  - up_si while full: ignored, and the buffer keeps its contents.
- Forward side (combinational from int_vc buffer):
  - If vc_full[int_vc] = 0: ring_req = pe_req = 0, fwd_do = 0.
  - Else let h = vc_buf[int_vc][8:15].
    - h == 0: pe_req = 1, fwd_do = held packet unchanged.
    - h != 0: ring_req = 1, ring_dir = held bit 1, fwd_do = held packet with hop field replaced by h - 1. All other bits, including the VC bit, are unchanged.
  - ring_req and pe_req are mutually exclusive.
- Grant handling:
  - A grant counts only when its matching request is high: (ring_req & ring_gnt) | (pe_req & pe_gnt).
  - On a counted grant, vc_full[int_vc] <= 0 at the next edge. Data registers need not be cleared.
  - A grant without a matching request is ignored.
- Latency:
  - Packet written at edge N appears on the outputs after the polarity toggles.
  - With alternating polarity: request visible in cycle N+1, at the earliest N+1 after write.
  - Granted in cycle N+1 → buffer free at edge N+2.
- Simultaneous events: a write to ext_vc and a counted grant on int_vc in the same cycle both take effect.
- Held polarity: if polarity does not toggle, the held int_vc packet keeps its request asserted, and ext_vc keeps accepting independently.
- Hop arithmetic: 8-bit unsigned, no wrap. The decrement is applied only when h != 0.

Test Plan:
- Reset mid-operation: fill VC0 (polarity=1, up_di[0]=0, hop=3), assert reset asynchronously between edges → vc_full=00, ring_req=0, up_ri=1 immediately, without waiting for a clock edge.
- Ring forward: polarity=1, write packet VC0 hop=0x03 dir=1. Next cycle polarity=0 → ring_req=1, ring_dir=1, fwd_do[8:15]=0x02. Assert ring_gnt → vc_full[0]=0 after the edge.
- Ejection: write VC1 packet with hop=0x00 at polarity=0. Next cycle polarity=1 → pe_req=1, ring_req=0, fwd_do equals the written packet bit-exact. pe_gnt clears vc_full[1].
- Backpressure: VC0 full, polarity=1 → up_ri=0. A new packet driven with up_si=1 is not written, and the held data is unchanged when later forwarded.
- Mismatched VC: polarity=1, up_si=1 with up_di[0]=1 → vc_full stays 00.
- Concurrent traffic:
  - Stimulus: polarity alternating, VC1 held and granted while a VC0 write arrives in the same cycle.
  - Required: vc_full goes 01→10.
  - Spurious pe_gnt with ring_req active is ignored.
